// File: rtl/ds_hazard_scoreboard_pkg.sv
// ds_hazard_scoreboard_pkg: shared constants and helpers for the decode hazard/forwarding unit
package ds_hazard_scoreboard_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int STG_EX     = 0;
    localparam int STG_MS     = 1;
    localparam int STG_WS     = 2;
    localparam int NSTG_DEF   = 3;

    // Select width needed to name the regfile plus every forwarding stage
    function automatic int sel_width(input int nstg);
        return $clog2(nstg + 1);
    endfunction

endpackage

// File: rtl/ds_hazard_scoreboard_sb_counter_bank.sv
// sb_counter_bank: per-register in-flight writer counters with flush and sticky underflow error
module sb_counter_bank
    import ds_hazard_scoreboard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_inc_we,
    input  logic [AW-1:0]      i_inc_dest,
    input  logic               i_dec_we,
    input  logic [AW-1:0]      i_dec_dest,
    output logic [NREG*CW-1:0] o_cnt,
    output logic               o_err
);

    logic [NREG-1:0][CW-1:0] r_cnt;
    logic [NREG-1:0][CW-1:0] w_cnt_nxt;
    logic                    r_err;
    logic                    w_err_set;

    // Next counts: issue increments, commit decrements, both together cancel; register 0 never tracked
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_set = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (i_inc_we && i_inc_dest == AW'(r) && !(i_dec_we && i_dec_dest == AW'(r))) begin
                if (r_cnt[r] != '1) w_cnt_nxt[r] = r_cnt[r] + 1'b1;
            end else if (i_dec_we && i_dec_dest == AW'(r) && !(i_inc_we && i_inc_dest == AW'(r))) begin
                if (r_cnt[r] != '0) w_cnt_nxt[r] = r_cnt[r] - 1'b1;
                else w_err_set = 1'b1;
            end
        end
    end

    // Counter state: reset clears everything, flush clears counts but keeps the error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= r_err | w_err_set;
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = r_err;

endmodule

// File: rtl/ds_hazard_scoreboard.sv
// ds_hazard_scoreboard: decode-stage forwarding select and stall generation with in-flight writer tracking
module ds_hazard_scoreboard
    import ds_hazard_scoreboard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSTG = NSTG_DEF,
    parameter int CW   = 2,
    parameter int SW   = sel_width(NSTG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_issue_fire,
    input  logic               i_issue_we,
    input  logic [AW-1:0]      i_issue_dest,
    input  logic [AW-1:0]      i_rs,
    input  logic [AW-1:0]      i_rt,
    input  logic               i_rs_used,
    input  logic               i_rt_used,
    input  logic [NSTG*AW-1:0] i_stg_dest,
    input  logic [NSTG-1:0]    i_stg_res_valid,
    input  logic               i_wb_we,
    input  logic [AW-1:0]      i_wb_dest,
    input  logic               i_flush,
    output logic [SW-1:0]      o_rs_fwd_sel,
    output logic [SW-1:0]      o_rt_fwd_sel,
    output logic               o_ds_stall,
    output logic               o_sb_err
);

    logic [NREG*CW-1:0] w_cnt;
    logic [SW:0]        w_rs_lk;
    logic [SW:0]        w_rt_lk;
    logic               w_struct_stall;

    sb_counter_bank #(
        .NREG (NREG),
        .AW   (AW),
        .CW   (CW)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (i_flush),
        .i_inc_we   (i_issue_fire & i_issue_we),
        .i_inc_dest (i_issue_dest),
        .i_dec_we   (i_wb_we),
        .i_dec_dest (i_wb_dest),
        .o_cnt      (w_cnt),
        .o_err      (o_sb_err)
    );

    // Returns {stall, sel}: youngest matching stage wins; with no stage match, a pending writer stalls
    function automatic logic [SW:0] lookup(
        input logic              used,
        input logic [AW-1:0]     src,
        input logic              pend,
        input logic [NSTG*AW-1:0] dest,
        input logic [NSTG-1:0]   rvalid
    );
        logic [SW:0] res;
        res = {1'b0, SW'(FWD_SEL_RF)};
        if (used && src != '0) begin
            res = {pend, SW'(FWD_SEL_RF)};
            for (int k = NSTG - 1; k >= STG_EX; k--)
                if (dest[k*AW +: AW] == src) res = {~rvalid[k], SW'(k + 1)};
        end
        return res;
    endfunction

    assign w_rs_lk = lookup(i_rs_used, i_rs, w_cnt[int'(i_rs)*CW +: CW] != '0, i_stg_dest, i_stg_res_valid);
    assign w_rt_lk = lookup(i_rt_used, i_rt, w_cnt[int'(i_rt)*CW +: CW] != '0, i_stg_dest, i_stg_res_valid);

    // A full counter for the destination blocks issue so the count never wraps
    assign w_struct_stall = i_issue_we && i_issue_dest != '0 && w_cnt[int'(i_issue_dest)*CW +: CW] == '1;

    assign o_rs_fwd_sel = w_rs_lk[SW-1:0];
    assign o_rt_fwd_sel = w_rt_lk[SW-1:0];
    assign o_ds_stall   = w_rs_lk[SW] | w_rt_lk[SW] | w_struct_stall;

endmodule

// File: tb/tb_ds_hazard_scoreboard.sv
// tb_ds_hazard_scoreboard: directed checks of forwarding selects, stalls, counters and error flag
module tb_ds_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_issue_fire, i_issue_we;
    logic [4:0]  i_issue_dest, i_rs, i_rt, i_wb_dest;
    logic        i_rs_used, i_rt_used, i_wb_we, i_flush;
    logic [14:0] i_stg_dest;
    logic [2:0]  i_stg_res_valid;
    logic [1:0]  o_rs_fwd_sel, o_rt_fwd_sel;
    logic        o_ds_stall, o_sb_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ds_hazard_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .i_issue_fire    (i_issue_fire),
        .i_issue_we      (i_issue_we),
        .i_issue_dest    (i_issue_dest),
        .i_rs            (i_rs),
        .i_rt            (i_rt),
        .i_rs_used       (i_rs_used),
        .i_rt_used       (i_rt_used),
        .i_stg_dest      (i_stg_dest),
        .i_stg_res_valid (i_stg_res_valid),
        .i_wb_we         (i_wb_we),
        .i_wb_dest       (i_wb_dest),
        .i_flush         (i_flush),
        .o_rs_fwd_sel    (o_rs_fwd_sel),
        .o_rt_fwd_sel    (o_rt_fwd_sel),
        .o_ds_stall      (o_ds_stall),
        .o_sb_err        (o_sb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_issue_fire = 0; i_issue_we = 0; i_issue_dest = 0;
        i_rs = 0; i_rt = 0; i_rs_used = 0; i_rt_used = 0;
        i_stg_dest = 0; i_stg_res_valid = 0;
        i_wb_we = 0; i_wb_dest = 0; i_flush = 0;
    endtask

    task automatic issue(input logic [4:0] d);
        i_issue_fire = 1; i_issue_we = 1; i_issue_dest = d;
        tick();
        i_issue_fire = 0; i_issue_we = 0; i_issue_dest = 0;
    endtask

    task automatic commit(input logic [4:0] d);
        i_wb_we = 1; i_wb_dest = d;
        tick();
        i_wb_we = 0; i_wb_dest = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        i_rs = 5; i_rs_used = 1;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", o_rs_fwd_sel); end
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", o_ds_stall); end
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", o_sb_err); end
        idle();
    endtask

    task automatic test_forward();
        issue(8);
        i_stg_dest = {5'd0, 5'd0, 5'd8}; i_stg_res_valid = 3'b001;
        i_rs = 8; i_rs_used = 1;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd1) begin errors++; $display("FAIL fwd_ex_sel: got %0d exp 1", o_rs_fwd_sel); end
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall: got %b exp 0", o_ds_stall); end
        tick();
        i_stg_dest = {5'd0, 5'd8, 5'd0}; i_stg_res_valid = 3'b010;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd2) begin errors++; $display("FAIL fwd_ms_sel: got %0d exp 2", o_rs_fwd_sel); end
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL fwd_ms_stall: got %b exp 0", o_ds_stall); end
        i_stg_dest = 0; i_stg_res_valid = 0;
        commit(8);
        checks++; if (o_ds_stall !== 1'b0 || o_rs_fwd_sel !== 2'd0) begin errors++; $display("FAIL fwd_after_commit: stall %b sel %0d exp 0 0", o_ds_stall, o_rs_fwd_sel); end
        idle();
    endtask

    task automatic test_load_use();
        issue(9);
        i_stg_dest = {5'd0, 5'd0, 5'd9}; i_stg_res_valid = 3'b000;
        i_rt = 9; i_rt_used = 1;
        #1;
        checks++; if (o_ds_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b exp 1", o_ds_stall); end
        tick();
        i_stg_dest = {5'd0, 5'd9, 5'd0}; i_stg_res_valid = 3'b010;
        #1;
        checks++; if (o_rt_fwd_sel !== 2'd2) begin errors++; $display("FAIL load_use_sel: got %0d exp 2", o_rt_fwd_sel); end
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b exp 0", o_ds_stall); end
        i_stg_dest = 0; i_stg_res_valid = 0;
        commit(9);
        idle();
    endtask

    task automatic test_youngest();
        i_stg_dest = {5'd4, 5'd0, 5'd4}; i_stg_res_valid = 3'b101;
        i_rs = 4; i_rs_used = 1;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd1) begin errors++; $display("FAIL youngest_sel: got %0d exp 1", o_rs_fwd_sel); end
        i_stg_dest = {5'd4, 5'd0, 5'd0}; i_stg_res_valid = 3'b100;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd3) begin errors++; $display("FAIL wb_stage_sel: got %0d exp 3", o_rs_fwd_sel); end
        i_stg_dest = {5'd0, 5'd0, 5'd4}; i_stg_res_valid = 3'b000;
        i_rs_used = 0;
        #1;
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL unused_src_stall: got %b exp 0", o_ds_stall); end
        i_stg_dest = 0; i_stg_res_valid = 3'b111;
        i_rs = 0; i_rs_used = 1;
        #1;
        checks++; if (o_rs_fwd_sel !== 2'd0 || o_ds_stall !== 1'b0) begin errors++; $display("FAIL reg0_lookup: sel %0d stall %b exp 0 0", o_rs_fwd_sel, o_ds_stall); end
        idle();
    endtask

    task automatic test_out_of_window();
        issue(10);
        i_rs = 10; i_rs_used = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (o_ds_stall !== 1'b1) begin errors++; $display("FAIL oow_stall cycle %0d: got %b exp 1", c, o_ds_stall); end
            tick();
        end
        commit(10);
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL oow_release: got %b exp 0", o_ds_stall); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            i_issue_we = 1; i_issue_dest = 3;
            #1;
            checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL sat_issue%0d_stall: got %b exp 0", n, o_ds_stall); end
            issue(3);
        end
        i_issue_we = 1; i_issue_dest = 3;
        #1;
        checks++; if (o_ds_stall !== 1'b1) begin errors++; $display("FAIL sat_full_stall: got %b exp 1", o_ds_stall); end
        i_issue_we = 0;
        commit(3);
        i_issue_we = 1; i_issue_dest = 3;
        #1;
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL sat_after_commit: got %b exp 0", o_ds_stall); end
        i_issue_fire = 1; i_wb_we = 1; i_wb_dest = 3;
        tick();
        i_issue_fire = 0; i_wb_we = 0; i_wb_dest = 0;
        #1;
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL same_cycle_unchanged: got %b exp 0", o_ds_stall); end
        issue(3);
        i_issue_we = 1; i_issue_dest = 3;
        #1;
        checks++; if (o_ds_stall !== 1'b1) begin errors++; $display("FAIL same_cycle_refill: got %b exp 1", o_ds_stall); end
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err: got %b exp 0", o_sb_err); end
        idle();
    endtask

    task automatic test_flush();
        issue(11);
        i_flush = 1;
        tick();
        i_flush = 0;
        i_issue_we = 1; i_issue_dest = 3;
        i_rs = 11; i_rs_used = 1;
        #1;
        checks++; if (o_ds_stall !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b exp 0", o_ds_stall); end
        idle();
        commit(0);
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL reg0_commit_err: got %b exp 0", o_sb_err); end
    endtask

    task automatic test_sb_err();
        commit(7);
        checks++; if (o_sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_set: got %b exp 1", o_sb_err); end
        i_flush = 1;
        tick();
        i_flush = 0;
        tick(); tick();
        checks++; if (o_sb_err !== 1'b1) begin errors++; $display("FAIL sb_err_sticky: got %b exp 1", o_sb_err); end
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_out_of_window();
        test_back_to_back();
        test_flush();
        test_sb_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_hazard_scoreboard.md
Name: ds_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the decode stage.
- Generalises fixed EX/MS/WS dest compare to NSTG forwarding stages.
- Adds a per-register in-flight writer scoreboard, so producers outside the forwarding window (long-latency units, multiple writers to one register) stall correctly.
- Sits beside id_stage: consumes issue handshake, per-stage dest/result-valid buses and the WB write port; produces per-source forward selects and a decode stall.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hardwired zero and never tracked.
- AW, 5, register address width (clog2(NREG)).
- NSTG, 3, forwarding stages; index 0 = youngest (EX), NSTG-1 = oldest (WB).
- CW, 2, pending-counter width; max in-flight writers per register = 2^CW-1.
- SW, 2, forward-select width (clog2(NSTG+1)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- issue_fire  in  1  decode instruction moves to EX this cycle (ds_to_es_valid & es_allowin).
- issue_we  in  1  issuing instruction writes a GPR.
- issue_dest  in  AW  issuing instruction destination.
- rs  in  AW  decode source 1 address.
- rt  in  AW  decode source 2 address.
- rs_used  in  1  decode instruction reads rs.
- rt_used  in  1  decode instruction reads rt.
- stg_dest  in  NSTG*AW  per-stage dest, slice k = stage k; already masked with stage valid & gr_we (0 = none).
- stg_res_valid  in  NSTG  stage k result is final and forwardable (0 for a load in EX).
- wb_we  in  1  regfile write this cycle.
- wb_dest  in  AW  regfile write address.
- flush  in  1  all in-flight instructions squashed.
- rs_fwd_sel  out  SW  0 = regfile, k+1 = stage k result.
- rt_fwd_sel  out  SW  same for rt.
- ds_stall  out  1  decode must not issue (ds_ready_go = ~ds_stall).
- sb_err  out  1  sticky: commit to a register with zero pending count.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- State: cnt[r], CW bits, for r = 1..NREG-1; sb_err flag.
- Reset: all cnt = 0, sb_err = 0. With cnt = 0, outputs are fwd_sel = 0 and ds_stall = 0.
- Count update, per register r != 0, per cycle:
  - inc = issue_fire & issue_we & issue_dest == r.
  - dec = wb_we & wb_dest == r.
  - inc & dec: no change.
  - inc only: +1.
  - dec only with cnt > 0: -1.
  - dec only with cnt == 0: no change; set sb_err.
- Priority: reset > flush (all cnt <- 0 next edge; sb_err kept) > update.
- Writes to register 0 are ignored everywhere.
- Source lookup, combinational, per source s in {rs, rt}:
  - hit[k] = used_s & s != 0 & stg_dest[k] == s.
  - Pick the lowest k with hit[k] (youngest producer).
  - If stg_res_valid[k]: fwd_sel = k+1, no stall. Else: stall.
  - No hit, cnt[s] == 0: fwd_sel = 0.
  - No hit, cnt[s] > 0: stall (producer outside the window).
  - WB same-cycle write is covered by stage NSTG-1; a regfile read in the cycle after is safe.
- Structural stall: issue_we & issue_dest != 0 & cnt[issue_dest] == 2^CW-1 asserts ds_stall; the counter never wraps.
- ds_stall is the OR of the rs, rt and structural stall terms. It is combinational and has no dependency on issue_fire (no loop).
- fwd_sel is meaningful only when ds_stall = 0.
- Latency: count changes are visible to the lookup on the cycle after the edge.

Decomposition:
- Shared package (mycpu.h defines): FWD_SEL_RF = 0, stage index constants (STG_EX = 0, STG_MS = 1, STG_WS = 2), SW derivation.
- Sub-module sb_counter_bank: the NREG-1 saturating up/down counters with flush, exposing a cnt vector and sb_err.
- Priority encoder and lookup stay in the top module.

Test Plan:
- Reset: reset = 1 for 2 cycles, then lookup rs = 5 with all stg_dest = 0 -> rs_fwd_sel = 0, ds_stall = 0, sb_err = 0.
- Forward from EX: issue addu dest 8; next cycle stg_dest[0] = 8, stg_res_valid[0] = 1, rs = 8 -> rs_fwd_sel = 1, no stall. Same with stg_dest[1] = 8 instead -> rs_fwd_sel = 2.
- Load-use: stg_dest[0] = 9, stg_res_valid[0] = 0, rt = 9 -> ds_stall = 1. Next cycle stg_dest[1] = 9, stg_res_valid[1] = 1 -> rt_fwd_sel = 2, ds_stall = 0.
- Youngest wins, and register 0 is ignored:
  - stg_dest[0] = 4 and stg_dest[2] = 4, both valid -> fwd_sel = 1.
  - rs = 0 with stg_dest[0] = 0 -> fwd_sel = 0.
- Out-of-window producer: issue writes to 10, no stg_dest = 10 for 6 cycles -> ds_stall = 1 for rs = 10. On wb_we with wb_dest = 10 -> cnt[10] = 0, stall drops the next cycle.
- Boundaries:
  - Three issues to reg 3 (CW = 2) -> fourth issue stalls.
  - Same-cycle issue and commit to reg 3 -> cnt unchanged.
  - flush -> all cnt = 0.
  - wb_dest = 7 with cnt[7] = 0 -> sb_err = 1, and it stays 1.
